// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared types and constants for the nibble-serial comparator
//            sequencer (state encoding, nibble width, result codes).
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encoding of a recorded nibble difference (pending register in
  // constant-time mode) and of the final latched result.
  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cmp_nibble.sv
`default_nettype none
// ============================================================================
// Module   : cmp_nibble
// Purpose  : Combinational 4-bit unsigned magnitude comparator slice.
//            Exactly one of eq/gt/lt is high for any input pair.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_nibble
  import cmp_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (x == y);
  assign gt = (x > y);
  assign lt = (x < y);

endmodule
`default_nettype wire

// File: rtl/cmp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cmp_seq_ctrl
// Purpose  : Compares two wide unsigned operands one nibble per clock through
//            a single shared cmp_nibble slice, MSB nibble first, with a
//            start/busy/done handshake and a latched one-hot result.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int NIBBLES    = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic                     eq,
  output logic                     gt,
  output logic                     lt,
  output logic [3:0]               steps
);

  localparam int         W      = NIB_W * NIBBLES;
  localparam logic [3:0] C_N    = 4'(NIBBLES);
  localparam logic [3:0] C_LAST = 4'(NIBBLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [3:0]       r_idx;
  logic [1:0]       r_pend;
  logic [1:0]       w_pend_nx;
  logic [1:0]       w_res;
  logic [1:0]       w_slice_res;
  logic             w_accept;
  logic             w_step;
  logic             w_load;
  logic [NIB_W-1:0] w_xa;
  logic [NIB_W-1:0] w_xb;
  logic             w_seq;
  logic             w_sgt;
  logic             w_slt;

  // Select the nibble currently addressed by the index from both operands.
  always_comb begin
    w_xa = '0;
    w_xb = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == 4'(i)) begin
        w_xa = r_a[i*NIB_W +: NIB_W];
        w_xb = r_b[i*NIB_W +: NIB_W];
      end
    end
  end

  cmp_nibble u_slice (
    .x  (w_xa),
    .y  (w_xb),
    .eq (w_seq),
    .gt (w_sgt),
    .lt (w_slt)
  );

  assign w_slice_res = w_seq ? RES_EQ : (w_sgt ? RES_GT : RES_LT);

  // Only the MSB-most difference is kept; once recorded it is never replaced.
  assign w_pend_nx = ((r_pend == RES_EQ) && !w_seq) ? w_slice_res : r_pend;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic, accept/step/load strobes and result selection.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_load   = 1'b0;
    w_res    = RES_EQ;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end
      end
      RUN: begin
        if (EARLY_EXIT && !w_seq) begin
          w_next = DONE;
          w_load = 1'b1;
          w_res  = w_slice_res;
        end else if (r_idx == 4'd0) begin
          w_next = DONE;
          w_load = 1'b1;
          if (EARLY_EXIT)               w_res = w_slice_res;
          else if (r_pend != RES_EQ)    w_res = r_pend;
          else                          w_res = w_slice_res;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, nibble index, pending difference and result latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= C_LAST;
      r_pend <= RES_EQ;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      steps  <= 4'd0;
    end else begin
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_idx  <= C_LAST;
        r_pend <= RES_EQ;
      end else if (w_step) begin
        r_idx  <= r_idx - 4'd1;
        r_pend <= w_pend_nx;
      end
      if (w_load) begin
        eq    <= (w_res == RES_EQ);
        gt    <= (w_res == RES_GT);
        lt    <= (w_res == RES_LT);
        steps <= C_N - r_idx;
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule
`default_nettype wire
